// File: rtl/alu_mdu_unit_pkg.sv
// Shared opcode encoding, FSM state type and opcode-class helpers for the
// EXU ALU/MDU slice.
package alu_mdu_unit_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLT    = 5'd5,
    ALU_SLTU   = 5'd6,
    ALU_SLL    = 5'd7,
    ALU_SRL    = 5'd8,
    ALU_SRA    = 5'd9,
    ALU_COPY_A = 5'd10,
    ALU_COPY_B = 5'd11,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23
  } alusel_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } alu_state_e;

  // M-extension opcodes occupy 16..23: bit2 selects divide, bits[1:0] the variant
  function automatic logic is_mdu_op(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

  function automatic logic is_alu_op(input logic [4:0] op);
    return op <= ALU_COPY_B;
  endfunction

endpackage

// File: rtl/alu_mdu_unit_if.sv
// Request/response channel between EXU issue, the ALU/MDU unit and writeback.
interface alu_mdu_unit_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
);
  import alu_mdu_unit_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [4:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  modport master (
    output in_valid, in_a, in_b, in_op, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_tag, flush, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_illegal
  );

endinterface

// File: rtl/alu_mdu_unit_muldiv_iter.sv
// Iterative multiply (shift-add) / divide (restoring) engine, one bit per
// cycle on operand magnitudes, with sign fixup and div-by-zero/overflow fast paths.
module muldiv_iter
  import alu_mdu_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_flush,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo;

  logic             w_div, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
  logic             w_dz, w_ovf, w_fast, w_ge;
  logic [WIDTH-1:0] w_mag_a, w_mag_b, w_opnd, w_cur_hi, w_cur_lo;
  logic [WIDTH-1:0] w_nxt_hi, w_nxt_lo, w_diff, w_fast_res, w_quo, w_rem;
  logic [WIDTH:0]   w_sum, w_sh;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;

  assign w_div   = i_op[2];
  assign w_sgn_a = w_div ? !i_op[0] : (i_op[1:0] != 2'b11);
  assign w_sgn_b = w_div ? !i_op[0] : !i_op[1];
  assign w_neg_a = w_sgn_a && i_a[WIDTH-1];
  assign w_neg_b = w_sgn_b && i_b[WIDTH-1];
  assign w_mag_a = w_neg_a ? -i_a : i_a;
  assign w_mag_b = w_neg_b ? -i_b : i_b;
  assign w_opnd  = w_div ? w_mag_b : w_mag_a;

  // First iteration seeds from the captured operands rather than the working regs
  assign w_cur_hi = (r_cnt == '0) ? '0 : r_hi;
  assign w_cur_lo = (r_cnt == '0) ? (w_div ? w_mag_a : w_mag_b) : r_lo;

  assign w_sum  = {1'b0, w_cur_hi} + (w_cur_lo[0] ? {1'b0, w_opnd} : '0);
  assign w_sh   = {w_cur_hi, w_cur_lo[WIDTH-1]};
  assign w_ge   = w_sh >= {1'b0, w_opnd};
  assign w_diff = w_sh[WIDTH-1:0] - w_opnd;

  always_comb begin
    w_nxt_hi = w_sum[WIDTH:1];
    w_nxt_lo = {w_sum[0], w_cur_lo[WIDTH-1:1]};
    if (w_div) begin
      w_nxt_hi = w_ge ? w_diff : w_sh[WIDTH-1:0];
      w_nxt_lo = {w_cur_lo[WIDTH-2:0], w_ge};
    end
  end

  assign w_dz       = w_div && (i_b == '0);
  assign w_ovf      = w_div && !i_op[0] && (i_a == MIN_VAL) && (i_b == '1);
  assign w_fast     = w_dz || w_ovf;
  assign w_fast_res = w_dz ? (i_op[1] ? i_a : '1) : (i_op[1] ? '0 : MIN_VAL);

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = (w_neg_a ^ w_neg_b) ? -w_prod : w_prod;
  assign w_quo    = (w_neg_a ^ w_neg_b) ? -r_lo : r_lo;
  assign w_rem    = w_neg_a ? -r_hi : r_hi;

  always_comb begin
    o_result = (i_op[1:0] == 2'b00) ? w_prod_s[WIDTH-1:0] : w_prod_s[2*WIDTH-1:WIDTH];
    if (w_fast) begin
      o_result = w_fast_res;
    end else if (w_div) begin
      o_result = i_op[1] ? w_rem : w_quo;
    end
  end

  assign o_done = r_busy && (w_fast || (r_cnt == CNT_W'(WIDTH-1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else if (i_flush) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
    end else if (r_busy) begin
      r_hi <= w_nxt_hi;
      r_lo <= w_nxt_lo;
      if (o_done) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_mdu_unit.sv
// RV32IM EXU ALU with iterative MUL/DIV over a valid/ready request/response pair.
// Optional feature macro: ALU_MDU_EN (defined: M ops executed; undefined: M ops illegal).
module alu_mdu_unit
  import alu_mdu_unit_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rst,
  alu_mdu_unit_if.slave   bus
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       op;
    logic [TAG_W-1:0] tag;
  } alu_req_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } alu_rsp_t;

  alu_state_e       r_state, w_state_nxt;
  alu_req_t         r_req;
  alu_rsp_t         w_rsp;
  logic             w_in_ready, w_fire, w_in_mdu, w_req_mdu, w_eng_done, w_illegal;
  logic [WIDTH-1:0] w_alu_res, w_eng_res;
  logic [SHAMT_W-1:0] w_shamt;

`ifdef ALU_MDU_EN
  assign w_in_mdu  = is_mdu_op(bus.in_op);
  assign w_req_mdu = is_mdu_op(r_req.op);

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_fire && w_in_mdu),
    .i_flush  (bus.flush),
    .i_op     (r_req.op[2:0]),
    .i_a      (r_req.a),
    .i_b      (r_req.b),
    .o_done   (w_eng_done),
    .o_result (w_eng_res)
  );
`else
  assign w_in_mdu   = 1'b0;
  assign w_req_mdu  = 1'b0;
  assign w_eng_done = 1'b0;
  assign w_eng_res  = '0;
`endif

  assign w_in_ready    = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
  assign w_fire        = bus.in_valid && w_in_ready && !bus.flush;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_DONE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_fire) w_state_nxt = w_in_mdu ? S_BUSY : S_DONE;
      S_BUSY: if (w_eng_done) w_state_nxt = S_DONE;
      S_DONE: begin
        if (w_fire) begin
          w_state_nxt = w_in_mdu ? S_BUSY : S_DONE;
        end else if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_req   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fire) begin
        r_req <= '{a: bus.in_a, b: bus.in_b, op: bus.in_op, tag: bus.in_tag};
      end
    end
  end

  assign w_shamt = r_req.b[SHAMT_W-1:0];

  always_comb begin
    w_alu_res = '0;
    case (r_req.op)
      ALU_ADD:    w_alu_res = r_req.a + r_req.b;
      ALU_SUB:    w_alu_res = r_req.a - r_req.b;
      ALU_AND:    w_alu_res = r_req.a & r_req.b;
      ALU_OR:     w_alu_res = r_req.a | r_req.b;
      ALU_XOR:    w_alu_res = r_req.a ^ r_req.b;
      ALU_SLT:    w_alu_res = WIDTH'($signed(r_req.a) < $signed(r_req.b));
      ALU_SLTU:   w_alu_res = WIDTH'(r_req.a < r_req.b);
      ALU_SLL:    w_alu_res = r_req.a << w_shamt;
      ALU_SRL:    w_alu_res = r_req.a >> w_shamt;
      ALU_SRA:    w_alu_res = $unsigned($signed(r_req.a) >>> w_shamt);
      ALU_COPY_A: w_alu_res = r_req.a;
      ALU_COPY_B: w_alu_res = r_req.b;
      default:    w_alu_res = '0;
    endcase
  end

  // Response is a pure function of the captured request, so it holds under backpressure
  assign w_illegal    = !(is_alu_op(r_req.op) || w_req_mdu);
  assign w_rsp.data    = w_illegal ? '0 : (w_req_mdu ? w_eng_res : w_alu_res);
  assign w_rsp.tag     = r_req.tag;
  assign w_rsp.illegal = w_illegal;

  assign bus.out_data    = w_rsp.data;
  assign bus.out_tag     = w_rsp.tag;
  assign bus.out_illegal = w_rsp.illegal;

endmodule
